display_timing_gen: RTL and testbench
=====================================

// Module: display_timing_gen
// PURPOSE
//  Display timing generator sitting directly downstream of display_controller.
//  Consumes its 32-bit pixel word stream (valid/ready) and drives the LCD panel interface
//  (RGB888 data, DE, HSYNC, VSYNC) from programmable H/V counters.
//  Detects stream underflow and frame misalignment, and resynchronises on start-of-frame.
// PARAMETERS
//  H_ACTIVE 640  visible pixels per line;  H_FP 16  H_SYNC 96  H_BP 48  (pixel clocks)
//  V_ACTIVE 480  visible lines per frame;  V_FP 10  V_SYNC 2   V_BP 33  (lines)
//  HS_POL 0 / VS_POL 0   sync active level (0 = active-low)
//  UF_COLOR 24'h000000   colour driven on underflow or while not in RUN
// PORTS
//  clk            in   1   pixel clock
//  reset_n        in   1   asynchronous, active-low reset
//  enable         in   1   timing enable; 0 forces IDLE
//  pix_data       in   32  pixel word from display_controller; [23:0]=RGB888, [31:24] ignored
//  pix_sof        in   1   marks the first pixel of a frame, qualified by pix_valid
//  pix_valid      in   1   pix_data valid
//  pix_ready      out  1   pixel accepted when pix_valid & pix_ready
//  lcd_data       out  24  panel RGB
//  lcd_de         out  1   data enable
//  lcd_hsync      out  1   horizontal sync, polarity HS_POL
//  lcd_vsync      out  1   vertical sync, polarity VS_POL
//  frame_start    out  1   1-cycle pulse when h=0, v=0
//  underflow      out  1   sticky: active pixel with no valid word in RUN
//  misalign       out  1   sticky: pix_sof seen away from h=0, v=0 in RUN
//  clr_err        in   1   clears underflow and misalign (set wins if same cycle)
// BEHAVIOUR
//  Reset: counters 0, state IDLE, pix_ready 0, lcd_data UF_COLOR, lcd_de 0, syncs inactive,
//   frame_start/underflow/misalign 0. Reset mid-frame aborts immediately; no partial line resumes.
//  Counters: h_cnt 0..H_TOT-1, H_TOT=H_ACTIVE+H_FP+H_SYNC+H_BP; v_cnt advances on h wrap,
//   0..V_TOT-1. Both wrap to 0; counters run only when enable=1, held at 0 otherwise.
//  Regions: active = h<H_ACTIVE && v<V_ACTIVE; hsync asserted for
//   H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vsync likewise on v (whole lines).
//  Outputs registered: lcd_* reflect the counter state of the previous cycle (latency 1).
//  States:
//   IDLE: enable=0. pix_ready=0, outputs at reset values. enable=1 -> WAIT_SOF.
//   WAIT_SOF: timing runs, de/syncs driven, lcd_data=UF_COLOR. pix_ready=1 for words without
//    pix_sof (discarded). Head word with pix_sof is held (pix_ready=0) until h=0,v=0, then
//    consumed as the first pixel -> RUN.
//   RUN: pix_ready = active. Accepted word -> lcd_data=pix_data[23:0].
//    active & !pix_valid -> lcd_data=UF_COLOR, underflow<=1, no word consumed, stay RUN.
//    Accepted word with pix_sof at (h,v)!=(0,0) -> misalign<=1, word not consumed, -> WAIT_SOF.
//    Word at (0,0) without pix_sof is accepted normally (no error).
//  enable falling in any state -> IDLE next cycle; lcd_de/syncs inactive, counters clear.
//  Blanking: lcd_data=UF_COLOR, lcd_de=0, pix_ready=0.
//  frame_start asserted with the registered outputs of pixel (0,0) in every state except IDLE.
// TESTING
//  Params 4/1/1/1 x 3/1/1/1, continuous valid stream beginning with sof -> DE 4 clks per line,
//   3 lines per frame, H_TOT=7, V_TOT=6, pixels appear in order 1 clk after (h,v).
//  3 non-sof words then sof word -> first three discarded, sof pixel output at (0,0), state RUN.
//  Drop pix_valid for 2 active clks -> 2 UF_COLOR pixels, underflow=1 stays until clr_err.
//  Inject sof at h=2,v=1 -> misalign=1, word held, back in RUN from next frame (0,0).
//  reset_n low mid-line -> all outputs at reset values immediately; enable low -> IDLE in 1 clk.
//  clr_err coincident with new underflow -> underflow remains 1.

Source files
------------

// File: rtl/display_timing_gen.sv
// Display timing generator: programmable H/V counters drive an RGB888 LCD
// interface from a valid/ready pixel stream. The generator locks to the stream
// on start-of-frame, flags underflow and misaligned SOF, and re-locks at the
// next frame origin.
//
// state        | meaning
// -------------+------------------------------------------------------------
// ST_IDLE      | enable low; counters held at 0, outputs at reset values
// ST_WAIT_SOF  | timing runs; non-SOF words discarded, SOF held until (0,0)
// ST_RUN       | locked; one word consumed per active pixel
module display_timing_gen #(
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0,
  parameter logic [23:0] UF_COLOR = 24'h000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [31:0] pix_data,
  input  logic        pix_sof,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [23:0] lcd_data,
  output logic        lcd_de,
  output logic        lcd_hsync,
  output logic        lcd_vsync,
  output logic        frame_start,
  output logic        underflow,
  output logic        misalign,
  input  logic        clr_err
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT + 1);
  localparam int VW    = $clog2(V_TOT + 1);

  localparam logic [HW-1:0] H_ACT_L  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS_L   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE_L   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST_L = HW'(H_TOT - 1);
  localparam logic [VW-1:0] V_ACT_L  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS_L   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE_L   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST_L = VW'(V_TOT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_SOF, ST_RUN} state_t;

  state_t          state;
  logic [HW-1:0]   h_cnt;
  logic [VW-1:0]   v_cnt;
  logic            active;
  logic            origin;
  logic            hs_on;
  logic            vs_on;
  logic            sof_early;
  logic            unused_hi;

  // The upper byte of the pixel word carries nothing for the panel.
  assign unused_hi = ^pix_data[31:24];

  // Region decode from the current counters and the stream handshake.
  always_comb begin
    active    = (h_cnt < H_ACT_L) && (v_cnt < V_ACT_L);
    origin    = (h_cnt == '0) && (v_cnt == '0);
    hs_on     = (h_cnt >= H_SS_L) && (h_cnt < H_SE_L);
    vs_on     = (v_cnt >= V_SS_L) && (v_cnt < V_SE_L);
    sof_early = pix_valid && pix_sof && !origin;
    pix_ready = 1'b0;
    if (enable) begin
      case (state)
        // SOF waits at the head of the stream until the frame origin.
        ST_WAIT_SOF: pix_ready = !pix_sof || origin;
        // A misplaced SOF is refused so it survives for the re-lock.
        ST_RUN:      pix_ready = active && !sof_early;
        default:     pix_ready = 1'b0;
      endcase
    end
  end

  // Raster counters: run only while timing is live, cleared otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!enable || state == ST_IDLE) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST_L) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST_L) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Sequencing FSM with registered panel outputs and sticky error flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      lcd_data    <= UF_COLOR;
      lcd_de      <= 1'b0;
      lcd_hsync   <= ~HS_POL;
      lcd_vsync   <= ~VS_POL;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
      misalign    <= 1'b0;
    end else begin
      lcd_data <= UF_COLOR;
      // Clear first so a same-cycle set below takes priority.
      if (clr_err) begin
        underflow <= 1'b0;
        misalign  <= 1'b0;
      end
      if (!enable || state == ST_IDLE) begin
        state       <= enable ? ST_WAIT_SOF : ST_IDLE;
        lcd_de      <= 1'b0;
        lcd_hsync   <= ~HS_POL;
        lcd_vsync   <= ~VS_POL;
        frame_start <= 1'b0;
      end else begin
        lcd_de      <= active;
        lcd_hsync   <= hs_on ? HS_POL : ~HS_POL;
        lcd_vsync   <= vs_on ? VS_POL : ~VS_POL;
        frame_start <= origin;
        case (state)
          ST_WAIT_SOF: begin
            if (pix_valid && pix_ready && pix_sof) begin
              lcd_data <= pix_data[23:0];
              state    <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (active) begin
              if (sof_early) begin
                misalign <= 1'b1;
                state    <= ST_WAIT_SOF;
              end else if (pix_valid) begin
                lcd_data <= pix_data[23:0];
              end else begin
                underflow <= 1'b1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_display_timing_gen.sv
// Bench for display_timing_gen with a 4/1/1/1 x 3/1/1/1 raster (7 x 6 totals):
// a vector table for the first line, directed corner-case sequences, then a
// randomized stream checked against a raster-arithmetic reference model.
module tb_display_timing_gen;

  localparam int HA = 4, HF = 1, HSY = 1, HB = 1;
  localparam int VA = 3, VF = 1, VSY = 1, VB = 1;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] pix_data = '0;
  logic        pix_sof = 1'b0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [23:0] lcd_data;
  logic        lcd_de;
  logic        lcd_hsync;
  logic        lcd_vsync;
  logic        frame_start;
  logic        underflow;
  logic        misalign;
  logic        clr_err = 1'b0;

  int checks = 0;
  int errors = 0;
  logic rdy_s;
  int pos;

  display_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .UF_COLOR(24'h000000)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .pix_data(pix_data), .pix_sof(pix_sof), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .lcd_data(lcd_data), .lcd_de(lcd_de),
    .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync), .frame_start(frame_start),
    .underflow(underflow), .misalign(misalign), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        s;
    logic [31:0] d;
    logic        e_rdy;
    logic        e_de;
    logic        e_hs;
    logic        e_vs;
    logic        e_fs;
    logic [23:0] e_data;
  } vec_t;

  vec_t tbl [9];

  // reference model state
  int          m_mode;   // 0 idle, 1 hunting for sof, 2 locked
  int          m_t;      // pixel clocks since the frame origin
  logic [23:0] e_data;
  logic        e_de, e_hs, e_vs, e_fs, e_uf, e_mis;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic en, input logic v, input logic s,
                      input logic [31:0] d, input logic c);
    @(negedge clk);
    enable = en; pix_valid = v; pix_sof = s; pix_data = d; clr_err = c;
    #1;
    rdy_s = pix_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, {31'd0, pix_ready}, 32'd0);
    chk({tag, "_data"}, {8'd0, lcd_data}, 32'd0);
    chk({tag, "_syncs_de_fs"}, {28'd0, lcd_de, lcd_hsync, lcd_vsync, frame_start}, 32'b0110);
    chk({tag, "_errs"}, {30'd0, underflow, misalign}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; enable = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0; clr_err = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Expected behaviour from the raster rules: position comes from elapsed
  // time since the origin, the lock is a simple hunting/locked flag.
  task automatic model(input logic en, input logic v, input logic s,
                       input logic [23:0] d, input logic c, output logic rdy);
    int h, vv;
    logic act, org, set_uf, set_mis;
    rdy = 1'b0; set_uf = 1'b0; set_mis = 1'b0; e_data = 24'h0;
    if (!en || m_mode == 0) begin
      e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0;
      m_mode = en ? 1 : 0;
      m_t = 0;
    end else begin
      h   = m_t % HT;
      vv  = m_t / HT;
      act = (h < HA) && (vv < VA);
      org = (m_t == 0);
      e_de = act;
      e_hs = !((h >= HA + HF) && (h < HA + HF + HSY));
      e_vs = !((vv >= VA + VF) && (vv < VA + VF + VSY));
      e_fs = org;
      if (m_mode == 1) begin
        rdy = !s || org;
        if (v && rdy && s) begin
          e_data = d;
          m_mode = 2;
        end
      end else if (act) begin
        if (v && s && !org) begin
          set_mis = 1'b1;
          m_mode = 1;
        end else begin
          rdy = 1'b1;
          if (v) e_data = d;
          else   set_uf = 1'b1;
        end
      end
      m_t = (m_t + 1) % (HT * VT);
    end
    if (c) begin e_uf = 1'b0; e_mis = 1'b0; end
    if (set_uf)  e_uf  = 1'b1;
    if (set_mis) e_mis = 1'b1;
  endtask

  initial begin
    logic        acc;
    logic [31:0] sw;
    logic        m_rdy;
    logic        en_r, have, w_sof, clr_r;
    logic [31:0] w_dat;
    int          off_cnt;

    tbl[0] = '{1'b1, 1'b1, 32'hFF111111, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000};
    tbl[1] = '{1'b1, 1'b1, 32'hFF111111, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 24'h111111};
    tbl[2] = '{1'b1, 1'b0, 32'h00222222, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 24'h222222};
    tbl[3] = '{1'b1, 1'b0, 32'h00333333, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 24'h333333};
    tbl[4] = '{1'b1, 1'b0, 32'h00444444, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 24'h444444};
    tbl[5] = '{1'b1, 1'b0, 32'h00555555, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000};
    tbl[6] = '{1'b1, 1'b0, 32'h00555555, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000000};
    tbl[7] = '{1'b1, 1'b0, 32'h00555555, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000};
    tbl[8] = '{1'b1, 1'b0, 32'h00555555, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 24'h555555};

    // reset values while reset is held
    #12;
    chk_reset_outs("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // first line from the vector table, stream starting with sof
    foreach (tbl[i]) begin
      step(1'b1, tbl[i].v, tbl[i].s, tbl[i].d, 1'b0);
      chk($sformatf("tbl%0d_ready", i), {31'd0, rdy_s}, {31'd0, tbl[i].e_rdy});
      chk($sformatf("tbl%0d_ctl", i), {28'd0, lcd_de, lcd_hsync, lcd_vsync, frame_start},
          {28'd0, tbl[i].e_de, tbl[i].e_hs, tbl[i].e_vs, tbl[i].e_fs});
      chk($sformatf("tbl%0d_data", i), {8'd0, lcd_data}, {8'd0, tbl[i].e_data});
    end

    // three non-sof words discarded, sof word held until the next origin
    do_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    pos = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h00ABC000 + i, 1'b0);
      chk("discard_ready", {31'd0, rdy_s}, 32'd1);
      chk("discard_data", {8'd0, lcd_data}, 32'd0);
      if (i == 0) chk("discard_fs", {31'd0, frame_start}, 32'd1);
      pos++;
    end
    sw = 32'h77A5C33C;
    acc = 1'b0;
    for (int k = 0; k < 60 && !acc; k++) begin
      step(1'b1, 1'b1, 1'b1, sw, 1'b0);
      acc = rdy_s;
      if (!acc) pos++;
    end
    chk("sof_accept_pos", pos, 32'd42);
    chk("sof_pixel", {8'd0, lcd_data}, {8'd0, sw[23:0]});
    chk("sof_fs", {31'd0, frame_start}, 32'd1);
    pos++;

    // two dropped active pixels -> underflow, sticky until clr_err
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("uf_data0", {8'd0, lcd_data}, 32'd0);
    chk("uf_set", {31'd0, underflow}, 32'd1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("uf_data1", {8'd0, lcd_data}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'h00123456, 1'b0);
    chk("resume_data", {8'd0, lcd_data}, 32'h00123456);
    chk("uf_sticky", {31'd0, underflow}, 32'd1);
    step(1'b1, 1'b1, 1'b0, 32'h00654321, 1'b1);
    chk("blank_ready", {31'd0, rdy_s}, 32'd0);
    chk("uf_clr", {31'd0, underflow}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("blank_no_uf", {31'd0, underflow}, 32'd0);
    // clr_err coincident with a new underflow at (0,1)
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("uf_set_wins", {31'd0, underflow}, 32'd1);
    step(1'b1, 1'b1, 1'b0, 32'h00BEEF01, 1'b0);
    chk("run_data", {8'd0, lcd_data}, 32'h00BEEF01);

    // sof injected at h=2, v=1 -> misalign, held, re-lock at next origin
    sw = 32'h00C0FFEE;
    step(1'b1, 1'b1, 1'b1, sw, 1'b0);
    chk("mis_ready", {31'd0, rdy_s}, 32'd0);
    chk("mis_set", {31'd0, misalign}, 32'd1);
    chk("mis_data", {8'd0, lcd_data}, 32'd0);
    pos = 51;
    acc = 1'b0;
    for (int k = 0; k < 60 && !acc; k++) begin
      pos++;
      step(1'b1, 1'b1, 1'b1, sw, 1'b0);
      acc = rdy_s;
    end
    chk("relock_pos", pos, 32'd84);
    chk("relock_pixel", {8'd0, lcd_data}, {8'd0, sw[23:0]});
    chk("relock_fs", {31'd0, frame_start}, 32'd1);
    step(1'b1, 1'b1, 1'b0, 32'h00ABCDEF, 1'b0);
    chk("relock_run", {8'd0, lcd_data}, 32'h00ABCDEF);
    chk("mis_sticky", {31'd0, misalign}, 32'd1);

    // enable low -> IDLE within one clock, counters cleared
    step(1'b0, 1'b1, 1'b0, 32'h00111000, 1'b0);
    chk("dis_ready", {31'd0, rdy_s}, 32'd0);
    chk("dis_ctl", {28'd0, lcd_de, lcd_hsync, lcd_vsync, frame_start}, 32'b0110);
    chk("dis_data", {8'd0, lcd_data}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'h00111000, 1'b0);
    chk("idle_ready", {31'd0, rdy_s}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'h00111000, 1'b0);
    chk("restart_fs", {31'd0, frame_start}, 32'd1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("restart_de", {31'd0, lcd_de}, 32'd1);

    // reset mid-line acts immediately
    reset_n = 1'b0;
    #2;
    chk_reset_outs("midreset");
    @(negedge clk);
    reset_n = 1'b1;

    // randomized stream against the reference model
    do_reset();
    m_mode = 0; m_t = 0; e_uf = 1'b0; e_mis = 1'b0;
    have = 1'b0; w_sof = 1'b0; w_dat = '0; off_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      if (off_cnt > 0) off_cnt--;
      else if ($urandom_range(0, 299) == 0) off_cnt = $urandom_range(1, 5);
      en_r  = (off_cnt == 0);
      clr_r = ($urandom_range(0, 49) == 0);
      if (!have && $urandom_range(0, 99) < 85) begin
        have  = 1'b1;
        w_sof = ($urandom_range(0, 24) == 0);
        w_dat = $urandom;
      end
      model(en_r, have, have && w_sof, w_dat[23:0], clr_r, m_rdy);
      step(en_r, have, have && w_sof, w_dat, clr_r);
      chk("rnd_ready", {31'd0, rdy_s}, {31'd0, m_rdy});
      chk("rnd_outs",
          {2'd0, lcd_data, lcd_de, lcd_hsync, lcd_vsync, frame_start, underflow, misalign},
          {2'd0, e_data, e_de, e_hs, e_vs, e_fs, e_uf, e_mis});
      if (have && m_rdy) have = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
